lazy_summary_pipeline_flow: RTL and testbench

- Parametrised successor to the lazy-match summary stage in the match engine.
- Takes one lazy-match window per beat: LAZY_LEN candidate matches starting at match_head_ptr. Scores each candidate by a configurable gain and picks the best.
- Emits one sequence summary per beat: ll, ml, offset, end-of-job, overlap and forward move.
- Adds valid/ready flow control with whole-pipeline stall, runtime greedy mode, a minimum-match filter, a literal-only fallback, and saturating statistics counters.

---
 rtl/lazy_summary_pipeline_flow.sv | 267 ++++++++++++++++++++++++++
 tb/tb_lazy_summary_pipeline_flow.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lazy_summary_pipeline_flow.sv
// Lazy-match summary stage: scores LAZY_LEN candidates per window and emits one
// sequence summary per beat through a 4-stage pipeline with global-stall flow control.
module lazy_summary_pipeline_flow #(
  parameter int LAZY_LEN        = 4,
  parameter int JOB_LEN_LOG2    = 5,
  parameter int MATCH_LEN_WIDTH = 6,
  parameter int SEQ_OFFSET_BITS = 16,
  parameter int SEQ_LL_BITS     = 16,
  parameter int SEQ_ML_BITS     = 16,
  parameter int ML_WEIGHT_SHIFT = 2,
  parameter int LIT_WEIGHT      = 4,
  parameter int MIN_MATCH       = 4,
  parameter int CNT_BITS        = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  output logic                                  i_ready,
  input  logic                                  i_greedy,
  input  logic [JOB_LEN_LOG2-1:0]               i_match_head_ptr,
  input  logic [JOB_LEN_LOG2-1:0]               i_seq_head_ptr,
  input  logic                                  i_delim,
  input  logic [LAZY_LEN-1:0]                   i_match_valid,
  input  logic [LAZY_LEN*MATCH_LEN_WIDTH-1:0]   i_match_len,
  input  logic [LAZY_LEN*SEQ_OFFSET_BITS-1:0]   i_offset,
  output logic                                  o_valid,
  input  logic                                  o_ready,
  output logic [JOB_LEN_LOG2-1:0]               o_seq_head_ptr,
  output logic [SEQ_LL_BITS-1:0]                o_summary_ll,
  output logic [SEQ_ML_BITS-1:0]                o_summary_ml,
  output logic [SEQ_OFFSET_BITS-1:0]            o_summary_offset,
  output logic                                  o_summary_delim,
  output logic                                  o_summary_eoj,
  output logic [SEQ_ML_BITS-1:0]                o_summary_overlap_len,
  output logic                                  o_move_to_next_job,
  output logic [JOB_LEN_LOG2-1:0]               o_move_forward,
  output logic [CNT_BITS-1:0]                   o_seq_count,
  output logic [CNT_BITS-1:0]                   o_job_count
);
  localparam int JOB_LEN = 1 << JOB_LEN_LOG2;
  localparam int OB_W    = $clog2(SEQ_OFFSET_BITS + 1);
  localparam int MF_W    = MATCH_LEN_WIDTH + 1;

  typedef logic [JOB_LEN_LOG2-1:0]    ptr_t;
  typedef logic [MATCH_LEN_WIDTH-1:0] ml_t;
  typedef logic [SEQ_OFFSET_BITS-1:0] off_t;
  typedef logic [MF_W-1:0]            mf_t;

  function automatic logic [OB_W-1:0] bit_len(input off_t v);
    logic [OB_W-1:0] n;
    n = '0;
    for (int b = 0; b < SEQ_OFFSET_BITS; b++)
      if (v[b]) n = OB_W'(b + 1);
    return n;
  endfunction

  logic s0_valid, s1_valid, s2_valid, s3_valid, en;
  assign en      = ~(s3_valid & ~o_ready);
  assign i_ready = en;
  assign o_valid = s3_valid;

  // ---------------- S0: per-candidate decode ----------------
  ptr_t                in_ll[LAZY_LEN];
  ml_t                 in_ml[LAZY_LEN];
  off_t                in_off[LAZY_LEN];
  logic [LAZY_LEN-1:0] in_ok;
  int                  in_pregain[LAZY_LEN];

  always_comb begin
    in_ok = '0;
    for (int i = 0; i < LAZY_LEN; i++) begin
      in_ml[i]      = i_match_len[i*MATCH_LEN_WIDTH +: MATCH_LEN_WIDTH];
      in_off[i]     = i_offset[i*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS];
      in_ll[i]      = i_match_head_ptr - i_seq_head_ptr + ptr_t'(i);
      in_ok[i]      = i_match_valid[i] && (int'(in_ml[i]) >= MIN_MATCH);
      in_pregain[i] = (int'(in_ml[i]) << ML_WEIGHT_SHIFT) + LIT_WEIGHT * (LAZY_LEN - i);
    end
  end

  logic                s0_greedy, s0_delim;
  ptr_t                s0_seq_head;
  mf_t                 s0_fb_ll;
  logic [LAZY_LEN-1:0] s0_ok;
  ptr_t                s0_ll[LAZY_LEN];
  ml_t                 s0_ml[LAZY_LEN];
  off_t                s0_off[LAZY_LEN];
  logic [OB_W-1:0]     s0_obits[LAZY_LEN];
  int                  s0_pregain[LAZY_LEN];

  // Stage valid bits are the only pipeline state that needs clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (en) begin
      s0_valid <= i_valid;
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // NOTE: S0..S2 data registers carry no reset; their valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (en) begin
      s0_greedy   <= i_greedy;
      s0_delim    <= i_delim;
      s0_seq_head <= i_seq_head_ptr;
      s0_fb_ll    <= mf_t'(in_ll[0]) + mf_t'(LAZY_LEN);
      s0_ok       <= in_ok;
      for (int i = 0; i < LAZY_LEN; i++) begin
        s0_ll[i]      <= in_ll[i];
        s0_ml[i]      <= in_ml[i];
        s0_off[i]     <= in_off[i];
        s0_obits[i]   <= bit_len(in_off[i]);
        s0_pregain[i] <= in_pregain[i];
      end
    end
  end

  // ---------------- S1: gain and match-finish ----------------
  logic                s1_greedy, s1_delim;
  ptr_t                s1_seq_head;
  mf_t                 s1_fb_ll;
  logic [LAZY_LEN-1:0] s1_ok;
  ptr_t                s1_ll[LAZY_LEN];
  ml_t                 s1_ml[LAZY_LEN];
  off_t                s1_off[LAZY_LEN];
  mf_t                 s1_mf[LAZY_LEN];
  int                  s1_gain[LAZY_LEN];

  always_ff @(posedge clk) begin
    if (en) begin
      s1_greedy   <= s0_greedy;
      s1_delim    <= s0_delim;
      s1_seq_head <= s0_seq_head;
      s1_fb_ll    <= s0_fb_ll;
      s1_ok       <= s0_ok;
      for (int i = 0; i < LAZY_LEN; i++) begin
        s1_ll[i]   <= s0_ll[i];
        s1_ml[i]   <= s0_ml[i];
        s1_off[i]  <= s0_off[i];
        s1_mf[i]   <= mf_t'(s0_ml[i]) + mf_t'(s0_ll[i]);
        s1_gain[i] <= s0_pregain[i] - int'(s0_obits[i]);
      end
    end
  end

  // ---------------- S2: candidate selection ----------------
  logic                   sel_found;
  int                     best_gain;
  logic [SEQ_LL_BITS-1:0] nx2_ll;
  ml_t                    nx2_ml;
  off_t                   nx2_off;
  mf_t                    nx2_mf;

  always_comb begin
    sel_found = 1'b0;
    best_gain = 0;
    nx2_ll    = SEQ_LL_BITS'(s1_fb_ll);
    nx2_ml    = '0;
    nx2_off   = '0;
    nx2_mf    = s1_fb_ll;
    // Strict '>' keeps the lower index on a gain tie.
    for (int i = 0; i < LAZY_LEN; i++) begin
      if (s1_ok[i] && (!sel_found || s1_gain[i] > best_gain)) begin
        sel_found = 1'b1;
        best_gain = s1_gain[i];
        nx2_ll    = SEQ_LL_BITS'(s1_ll[i]);
        nx2_ml    = s1_ml[i];
        nx2_off   = s1_off[i];
        nx2_mf    = s1_mf[i];
      end
    end
    if (s1_greedy && s1_ok[0]) begin
      nx2_ll  = SEQ_LL_BITS'(s1_ll[0]);
      nx2_ml  = s1_ml[0];
      nx2_off = s1_off[0];
      nx2_mf  = s1_mf[0];
    end
  end

  logic                   s2_delim;
  ptr_t                   s2_seq_head;
  logic [SEQ_LL_BITS-1:0] s2_ll;
  ml_t                    s2_ml;
  off_t                   s2_off;
  mf_t                    s2_mf;

  always_ff @(posedge clk) begin
    if (en) begin
      s2_delim    <= s1_delim;
      s2_seq_head <= s1_seq_head;
      s2_ll       <= nx2_ll;
      s2_ml       <= nx2_ml;
      s2_off      <= nx2_off;
      s2_mf       <= nx2_mf;
    end
  end

  // ---------------- S3: job-end resolution ----------------
  int                     ovl;
  logic [SEQ_LL_BITS-1:0] nx3_ll;
  logic [SEQ_ML_BITS-1:0] nx3_ml, nx3_ovl;
  off_t                   nx3_off;
  logic                   nx3_eoj;
  ptr_t                   nx3_mv;

  always_comb begin
    ovl     = int'(s2_seq_head) + int'(s2_mf) - JOB_LEN;
    nx3_ll  = s2_ll;
    nx3_ml  = SEQ_ML_BITS'(s2_ml);
    nx3_off = s2_off;
    nx3_eoj = 1'b0;
    nx3_ovl = '0;
    nx3_mv  = ptr_t'(s2_mf);
    if (ovl >= 0) begin
      nx3_eoj = 1'b1;
      nx3_mv  = '0;
      if (s2_delim) begin
        // Last job of the block: flush the tail as literals only.
        nx3_ll  = SEQ_LL_BITS'(JOB_LEN) - SEQ_LL_BITS'(s2_seq_head);
        nx3_ml  = '0;
        nx3_off = '0;
      end else begin
        nx3_ovl = SEQ_ML_BITS'(ovl);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_seq_head_ptr        <= '0;
      o_summary_ll          <= '0;
      o_summary_ml          <= '0;
      o_summary_offset      <= '0;
      o_summary_delim       <= 1'b0;
      o_summary_eoj         <= 1'b0;
      o_summary_overlap_len <= '0;
      o_move_to_next_job    <= 1'b0;
      o_move_forward        <= '0;
    end else if (en) begin
      o_seq_head_ptr        <= s2_seq_head;
      o_summary_ll          <= nx3_ll;
      o_summary_ml          <= nx3_ml;
      o_summary_offset      <= nx3_off;
      o_summary_delim       <= s2_delim;
      o_summary_eoj         <= nx3_eoj;
      o_summary_overlap_len <= nx3_ovl;
      o_move_to_next_job    <= nx3_eoj;
      o_move_forward        <= nx3_mv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_seq_count <= '0;
      o_job_count <= '0;
    end else if (s3_valid && o_ready) begin
      if (o_seq_count != '1) o_seq_count <= o_seq_count + 1'b1;
      if (o_summary_eoj && o_job_count != '1) o_job_count <= o_job_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lazy_summary_pipeline_flow.sv
// Scoreboard bench for lazy_summary_pipeline_flow: directed beats push expected
// summaries; an independent monitor pops and compares on every output handshake.
module tb_lazy_summary_pipeline_flow;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, i_ready, i_greedy = 1'b0, i_delim = 1'b0;
  logic [4:0]  i_match_head_ptr = '0, i_seq_head_ptr = '0;
  logic [3:0]  i_match_valid = '0;
  logic [23:0] i_match_len = '0;
  logic [63:0] i_offset = '0;
  logic        o_valid, o_ready = 1'b1;
  logic [4:0]  o_seq_head_ptr, o_move_forward;
  logic [15:0] o_summary_ll, o_summary_ml, o_summary_offset, o_summary_overlap_len;
  logic        o_summary_delim, o_summary_eoj, o_move_to_next_job;
  logic [31:0] o_seq_count, o_job_count;

  lazy_summary_pipeline_flow dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_greedy(i_greedy),
    .i_match_head_ptr(i_match_head_ptr), .i_seq_head_ptr(i_seq_head_ptr), .i_delim(i_delim),
    .i_match_valid(i_match_valid), .i_match_len(i_match_len), .i_offset(i_offset),
    .o_valid(o_valid), .o_ready(o_ready), .o_seq_head_ptr(o_seq_head_ptr),
    .o_summary_ll(o_summary_ll), .o_summary_ml(o_summary_ml), .o_summary_offset(o_summary_offset),
    .o_summary_delim(o_summary_delim), .o_summary_eoj(o_summary_eoj),
    .o_summary_overlap_len(o_summary_overlap_len), .o_move_to_next_job(o_move_to_next_job),
    .o_move_forward(o_move_forward), .o_seq_count(o_seq_count), .o_job_count(o_job_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic greedy; logic [4:0] head, sh; logic delim; logic [3:0] mv;
    logic [23:0] ml; logic [63:0] off;
  } beat_t;
  typedef struct packed {
    logic [15:0] ll, ml, off; logic eoj; logic [15:0] ovl; logic nxt;
    logic [4:0] mvf; logic delim; logic [4:0] sh;
  } exp_t;

  exp_t  q[$];
  int    total = 0, bad = 0;
  beat_t bt[10];
  exp_t  ex[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic beat_t mkb(input logic g, input logic [4:0] h, input logic [4:0] s,
                                input logic d, input logic [3:0] v,
                                input logic [23:0] ml, input logic [63:0] off);
    beat_t b;
    b.greedy = g; b.head = h; b.sh = s; b.delim = d; b.mv = v; b.ml = ml; b.off = off;
    return b;
  endfunction

  function automatic exp_t mke(input int ll, input int ml, input int off, input logic eoj,
                               input int ovl, input logic nxt, input int mvf,
                               input logic d, input int sh);
    exp_t e;
    e.ll = 16'(ll); e.ml = 16'(ml); e.off = 16'(off); e.eoj = eoj; e.ovl = 16'(ovl);
    e.nxt = nxt; e.mvf = 5'(mvf); e.delim = d; e.sh = 5'(sh);
    return e;
  endfunction

  // Present one beat for one cycle; push its expectation only if it is accepted.
  task automatic offer(input beat_t b, input exp_t e, output bit acc);
    i_valid = 1'b1; i_greedy = b.greedy; i_match_head_ptr = b.head; i_seq_head_ptr = b.sh;
    i_delim = b.delim; i_match_valid = b.mv; i_match_len = b.ml; i_offset = b.off;
    @(negedge clk);
    acc = i_ready;
    if (acc) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input beat_t b, input exp_t e);
    bit acc;
    int tries = 0;
    do begin
      offer(b, e, acc);
      tries++;
    end while (!acc && tries < 50);
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compares every handed-off summary against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_valid && o_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'(o_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("ll",       32'(o_summary_ll),          32'(e.ll));
          check("ml",       32'(o_summary_ml),          32'(e.ml));
          check("offset",   32'(o_summary_offset),      32'(e.off));
          check("eoj",      32'(o_summary_eoj),         32'(e.eoj));
          check("overlap",  32'(o_summary_overlap_len), 32'(e.ovl));
          check("next_job", 32'(o_move_to_next_job),    32'(e.nxt));
          check("move_fwd", 32'(o_move_forward),        32'(e.mvf));
          check("delim",    32'(o_summary_delim),       32'(e.delim));
          check("seq_head", 32'(o_seq_head_ptr),        32'(e.sh));
        end
      end
    end
  end

  initial begin
    logic [23:0] ml_a;
    logic [63:0] off_a;
    int n, acc_cnt, eoj_cnt;
    bit acc;
    ml_a  = {6'd4, 6'd4, 6'd6, 6'd4};
    off_a = {16'h1, 16'h1, 16'h100, 16'h100};
    // Candidate gains for A: {23,27,23,19} -> candidate 1 wins.
    bt[0] = mkb(0, 10, 8, 0, 4'b1111, ml_a, off_a);
    ex[0] = mke(3, 6, 'h100, 0, 0, 0, 9, 0, 8);
    bt[1] = mkb(1, 10, 8, 0, 4'b1111, ml_a, off_a);
    ex[1] = mke(2, 4, 'h100, 0, 0, 0, 6, 0, 8);
    bt[2] = mkb(0, 28, 28, 0, 4'b0001, {18'd0, 6'd10}, {48'd0, 16'd5});
    ex[2] = mke(0, 10, 5, 1, 6, 1, 0, 0, 28);
    bt[3] = mkb(0, 28, 28, 1, 4'b0001, {18'd0, 6'd10}, {48'd0, 16'd5});
    ex[3] = mke(4, 0, 0, 1, 0, 1, 0, 1, 28);
    // Fallback: visible candidates below MIN_MATCH, long ones masked off.
    bt[4] = mkb(0, 10, 8, 0, 4'b0011, {6'd9, 6'd9, 6'd2, 6'd3}, {4{16'd7}});
    ex[4] = mke(6, 0, 0, 0, 0, 0, 6, 0, 8);
    // Tie at gain 23 between candidates 0 and 2 -> index 0.
    bt[5] = mkb(0, 10, 8, 0, 4'b0101, ml_a, off_a);
    ex[5] = mke(2, 4, 'h100, 0, 0, 0, 6, 0, 8);
    // Greedy with candidate 0 filtered out falls back to best gain.
    bt[6] = mkb(1, 10, 8, 0, 4'b1111, {6'd4, 6'd4, 6'd6, 6'd3}, off_a);
    ex[6] = mke(3, 6, 'h100, 0, 0, 0, 9, 0, 8);
    // ll wraps modulo 32 (2-30 -> 4); offset 0 has zero bit length.
    bt[7] = mkb(0, 2, 30, 0, 4'b0001, {18'd0, 6'd4}, 64'd0);
    ex[7] = mke(4, 4, 0, 1, 6, 1, 0, 0, 30);
    // Overlap exactly 0 vs -1 at the job boundary.
    bt[8] = mkb(0, 24, 24, 0, 4'b0001, {18'd0, 6'd8}, {48'd0, 16'd3});
    ex[8] = mke(0, 8, 3, 1, 0, 1, 0, 0, 24);
    bt[9] = mkb(0, 24, 24, 0, 4'b0001, {18'd0, 6'd7}, {48'd0, 16'd3});
    ex[9] = mke(0, 7, 3, 0, 0, 0, 7, 0, 24);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd1);
    check("rst_seq_cnt", o_seq_count, 32'd0);
    check("rst_ll",      32'(o_summary_ll), 32'd0);
    check("rst_eoj",     32'(o_summary_eoj), 32'd0);
    rst = 1'b0;

    // Single beat with latency measurement, then the rest back to back.
    send(bt[0], ex[0]);
    i_valid = 1'b0;
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (o_valid) break;
      @(posedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd4);
    @(posedge clk);
    #1;
    for (int k = 1; k < 10; k++) send(bt[k], ex[k]);
    i_valid = 1'b0;
    drain();
    eoj_cnt = 0;
    for (int k = 0; k < 10; k++) eoj_cnt += int'(ex[k].eoj);
    check("seq_count_10", o_seq_count, 32'd10);
    check("job_count_10", o_job_count, 32'(eoj_cnt));

    // Backpressure: 8 offered beats under o_ready=0, only 4 fit.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    o_ready = 1'b0;
    acc_cnt = 0;
    eoj_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? 3 : (k == 3) ? 7 :
            (k == 4) ? 4 : (k == 5) ? 5 : (k == 6) ? 6 : 8;
      offer(bt[idx], ex[idx], acc);
      if (acc) begin
        acc_cnt++;
        eoj_cnt += int'(ex[idx].eoj);
      end
    end
    i_valid = 1'b0;
    check("stall_accepted", 32'(acc_cnt), 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_i_ready", 32'(i_ready), 32'd0);
      check("stall_o_valid", 32'(o_valid), 32'd1);
      check("stall_ll",      32'(o_summary_ll), 32'(q[0].ll));
      check("stall_ml",      32'(o_summary_ml), 32'(q[0].ml));
    end
    @(posedge clk);
    #1;
    o_ready = 1'b1;
    drain();
    check("stall_seq_count", o_seq_count, 32'd4);
    check("stall_job_count", o_job_count, 32'(eoj_cnt));

    // Reset with three beats in flight.
    send(bt[0], ex[0]);
    send(bt[1], ex[1]);
    send(bt[2], ex[2]);
    i_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_o_valid", 32'(o_valid), 32'd0);
    check("midrst_seq_cnt", o_seq_count, 32'd0);
    check("midrst_job_cnt", o_job_count, 32'd0);
    check("midrst_i_ready", 32'(i_ready), 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midrst_quiet", 32'(o_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
